// File: rtl/parity_link_pkg.sv
// parity_link_pkg: state encoding and frame constants shared by the parity serial tx/rx pair
package parity_link_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} link_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/parity_serial_tx_baud.sv
// baud_tick_counter: counts clocks per serial bit, tick on the last clock of each bit
module baud_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  // pre_tick lets the owner register an output that must line up with the tick clock
  assign pre_tick = CLKS_PER_BIT > 1 && cnt == CW'(CLKS_PER_BIT - 2);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clear || tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: frames a parity-extended word as start|data LSB-first|parity|stop
module parity_serial_tx
  import parity_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_valid,
  input  logic [DATA_W:0] tx_data_par,
  output logic            tx_ready,
  output logic            serial_out,
  output logic            busy,
  output logic            frame_done
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  link_state_t state;
  logic [DATA_W:0] shift;
  logic [BW-1:0] bit_idx;
  logic tick, pre_tick;
  baud_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .tick(tick),
    .pre_tick(pre_tick)
  );
  // shift[0] always holds the next bit to send; after DATA_W shifts it is the parity bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      bit_idx <= '0;
      serial_out <= STOP_BIT;
      tx_ready <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == STOP && pre_tick) || (CLKS_PER_BIT == 1 && state == PARITY && tick);
      case (state)
        IDLE:
          if (tx_valid && tx_ready) begin
            shift <= tx_data_par;
            state <= START;
            serial_out <= START_BIT;
            tx_ready <= 1'b0;
            busy <= 1'b1;
          end
        START:
          if (tick) begin
            state <= DATA;
            serial_out <= shift[0];
            shift <= shift >> 1;
          end
        DATA:
          if (tick) begin
            serial_out <= shift[0];
            shift <= shift >> 1;
            bit_idx <= bit_idx == BW'(DATA_W - 1) ? '0 : bit_idx + 1'b1;
            if (bit_idx == BW'(DATA_W - 1)) state <= PARITY;
          end
        PARITY:
          if (tick) begin
            state <= STOP;
            serial_out <= STOP_BIT;
          end
        STOP:
          if (tick) begin
            state <= IDLE;
            tx_ready <= 1'b1;
            busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: random and directed frames on CLKS_PER_BIT=4 and =1 against a frame-position model
module tb_parity_serial_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_valid = 1'b0;
  logic [8:0] tx_data_par = '0;
  logic so[2], rdy[2], bsy[2], fd[2];
  int cpb[2] = '{4, 1};
  int pos[2] = '{-1, -1};
  logic [10:0] fbits[2];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data_par(tx_data_par),
    .tx_ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]), .frame_done(fd[0])
  );
  parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data_par(tx_data_par),
    .tx_ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]), .frame_done(fd[1])
  );
  task automatic check(input string name, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask
  // model: a frame is 11 bits {stop, parity, data, start}; pos is the clock index inside it
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) pos[k] = -1;
      else if (pos[k] < 0) begin
        if (tx_valid) begin
          fbits[k] = {1'b1, tx_data_par, 1'b0};
          pos[k] = 0;
        end
      end else pos[k] = pos[k] + 1 == 11 * cpb[k] ? -1 : pos[k] + 1;
  always @(negedge clk)
    if (!rst)
      for (int k = 0; k < 2; k++) begin
        check("serial_out", k, int'(so[k]), pos[k] >= 0 ? int'(fbits[k][pos[k] / cpb[k]]) : 1);
        check("busy", k, int'(bsy[k]), int'(pos[k] >= 0));
        check("tx_ready", k, int'(rdy[k]), int'(pos[k] < 0));
        check("frame_done", k, int'(fd[k]), int'(pos[k] == 11 * cpb[k] - 1));
      end
  task automatic wait_idle();
    int n = 0;
    while (n < 200 && !(rdy[0] && rdy[1])) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 0, int'(rdy[0] && rdy[1]), 1);
  endtask
  task automatic send(input logic [8:0] d);
    @(posedge clk);
    #1 tx_valid = 1'b1;
    tx_data_par = d;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask
  task automatic capture(input int k, input int cp, output logic [10:0] bits, output int done_at);
    bits = '1;
    done_at = -1;
    for (int c = 0; c < 11 * cp; c++) begin
      @(negedge clk);
      if (c % cp == cp / 2) bits[c / cp] = so[k];
      if (fd[k]) done_at = c;
    end
  endtask
  initial begin
    logic [10:0] bits;
    int done_at, n, idle;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_serial_out", k, int'(so[k]), 1);
      check("rst_tx_ready", k, int'(rdy[k]), 1);
      check("rst_busy", k, int'(bsy[k]), 0);
      check("rst_frame_done", k, int'(fd[k]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
    send(9'b0_1010_1010);
    capture(0, 4, bits, done_at);
    check("bits_0aa", 0, int'(bits), int'(11'b10101010100));
    check("done_at_0aa", 0, done_at, 43);
    wait_idle();
    send(9'b1_0111_1010);
    fork
      capture(0, 4, bits, done_at);
      begin
        repeat (12) @(posedge clk);
        #1 tx_valid = 1'b1;
        tx_data_par = 9'h1FF;
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    join
    check("bits_17a", 0, int'(bits), int'(11'b11011110100));
    check("done_at_17a", 0, done_at, 43);
    wait_idle();
    send(9'b1_0000_0000);
    capture(1, 1, bits, done_at);
    check("bits_cpb1", 1, int'(bits), int'(11'b11000000000));
    check("done_at_cpb1", 1, done_at, 10);
    wait_idle();
    @(posedge clk);
    #1 tx_valid = 1'b1;
    tx_data_par = 9'h0C3;
    n = 0;
    do begin @(negedge clk); n++; end while (rdy[0] && n < 10);
    tx_data_par = 9'h13C;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy[0] && n < 100);
    idle = 0;
    while (rdy[0] && idle < 10) begin
      check("gap_serial_high", 0, int'(so[0]), 1);
      idle++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("gap_len", 0, idle, 1);
    wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1 tx_valid = $urandom_range(0, 2) == 0;
      tx_data_par = 9'($urandom);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    #1 tx_valid = 1'b0;
    wait_idle();
    send(9'h000);
    #1 check("pre_abort_low", 0, int'(so[0]), 0);
    #2 rst = 1'b1;
    #1 for (int k = 0; k < 2; k++) begin
      check("abort_serial_out", k, int'(so[k]), 1);
      check("abort_frame_done", k, int'(fd[k]), 0);
      check("abort_busy", k, int'(bsy[k]), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_abort_ready", 0, int'(rdy[0]), 1);
    send(9'b1_0101_0101);
    capture(0, 4, bits, done_at);
    check("bits_after_abort", 0, int'(bits), int'(11'b11010101010));
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
